johnson_step_sequencer: RTL
===========================

# johnson_step_sequencer

Sequencing controller for the two-flop Johnson (twisted-ring) pattern generator used in our TinyTapeout tiles. The block owns the 4-state ring, decides when it advances (free-running at a programmable rate, or single-stepped on demand) and in which direction. It exposes the ring, advance and wrap strobes, and controller state on the standard 8-bit tile pins. Drops into a tile slot as a self-contained user module.

## Interface

Parameters:
- none; the pin map is fixed by the tile harness.

Ports (all on the tile bus; clock and reset first):
- io_in[0]  input  1  clk. Single clock; all state updates on its rising edge.
- io_in[1]  input  1  reset. Synchronous, active-high.
- io_in[2]  input  1  run. Level; 1 requests free-running advance.
- io_in[3]  input  1  step. Single-step request; rising edge acts.
- io_in[4]  input  1  dir. 0 = forward, 1 = reverse; sampled at each advance edge.
- io_in[7:5]  input  3  rate. Advance period in RUN = 2^rate cycles (1..128).
- io_out[1:0]  output  2  ring {B,A}: A = io_out[0], B = io_out[1].
- io_out[2]  output  1  tick. One-cycle strobe coincident with a new ring value.
- io_out[4:3]  output  2  FSM state code: 00 IDLE, 01 RUN, 10 STEP.
- io_out[5]  output  1  wrap. One-cycle strobe when an advance lands on ring 00.
- io_out[6]  output  1  last_dir. dir value used at the most recent advance.
- io_out[7]  output  1  step_drop. One-cycle strobe when a step edge is ignored.

## Operation

- Ring sequence, forward (A' = ~B, B' = A): 00 -> 10 -> 11 -> 01 -> 00, written as {A,B}.
- Ring sequence, reverse (A' = B, B' = ~A): 00 -> 01 -> 11 -> 10 -> 00.
- Step edge: step_edge = step & ~step_prev. step_prev is a register updated every cycle.
- Prescaler: 7-bit cnt; limit = (1 << rate) - 1.
- FSM states:
  - IDLE: ring holds. run=1 -> RUN with cnt <= 0. Else step_edge -> STEP. run takes priority over step_edge.
  - RUN: on each edge, if cnt >= limit, advance the ring, set cnt <= 0 and pulse tick. Otherwise cnt <= cnt+1.
  - RUN exit: run=0 -> IDLE with cnt <= 0. No advance occurs on the exit edge.
  - RUN, step_edge: ignored; step_drop pulses.
  - STEP: on the edge leaving STEP, advance the ring once, pulse tick, go to IDLE. run and step are ignored while in STEP.
  - Code 11: unreachable. Must return to IDLE on the next edge with the ring unchanged.
- rate may change at any time. If cnt > new limit, the next RUN edge advances and clears cnt (no wait for 7-bit wrap).
- wrap and last_dir update only on advancing edges. wrap = (new ring == 00).

## Timing

- All outputs registered; no combinational io_in -> io_out path.
- Reset values (the cycle after reset is sampled high): ring 00, state IDLE, cnt 0, tick 0, wrap 0, last_dir 0, step_drop 0, step_prev 1.
  - step_prev resets to 1, so a step held high through reset does not trigger a step.
- Reset dominates all other inputs, including mid-RUN and during STEP. An in-flight advance is discarded.
- run sampled high in IDLE at edge N:
  - state = RUN after edge N.
  - First advance at edge N + 2^rate; subsequent advances every 2^rate edges while run stays 1.
  - rate=0: advance every cycle starting at edge N+1.
- step edge sampled in IDLE at edge N: STEP after N; ring advances, tick=1 and state=IDLE after N+1. Minimum step-to-step spacing is 2 cycles.
- A step edge arriving on the same edge the FSM leaves STEP sees state STEP and is lost silently (no step_drop).
- tick, wrap and step_drop are high for exactly one cycle per event.

## Test plan

- Reset/hold: assert reset 3 cycles with step=1, run=0, then release.
  - Required: ring 00, state 00, all strobes 0; no advance while step stays high.
- Single-step forward: 4 step pulses, dir=0.
  - Required: ring {A,B} = 10, 11, 01, 00, each with tick=1 one cycle after STEP; wrap=1 only on the 4th.
- Single-step reverse: dir=1, 4 pulses.
  - Required: ring 01, 11, 10, 00; last_dir=1.
- Run rate: rate=3, run=1 for 40 cycles.
  - Required: first tick 8 cycles after RUN entry, then every 8 cycles (5 ticks); wrap on the 4th tick.
  - Repeat with rate=0: tick every cycle.
- Rate drop mid-count: rate=7, run=1, wait 50 cycles, set rate=2.
  - Required: advance on the next edge, then every 4 cycles.
- Interference: pulse step during RUN -> step_drop=1 for one cycle, ring cadence unchanged. Assert reset mid-RUN -> ring 00, IDLE next cycle.

Source files
------------

// File: rtl/johnson_step_sequencer.sv
// Two-flop Johnson ring sequencer for a TinyTapeout tile: free-running advance
// at 2^rate cycles or single-stepped on a step rising edge, forward or reverse.
module johnson_step_sequencer (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    BAD  = 2'b11
  } state_t;

  logic       clk;
  logic       reset;
  logic       run;
  logic       step;
  logic       dir;
  logic [2:0] rate;

  assign clk   = io_in[0];
  assign reset = io_in[1];
  assign run   = io_in[2];
  assign step  = io_in[3];
  assign dir   = io_in[4];
  assign rate  = io_in[7:5];

  state_t     state;
  state_t     state_n;
  logic [6:0] cnt;
  logic [6:0] cnt_n;
  logic [6:0] limit;
  logic       ring_a;
  logic       ring_b;
  logic       ring_a_n;
  logic       ring_b_n;
  logic       tick;
  logic       wrap;
  logic       last_dir;
  logic       step_drop;
  logic       step_drop_n;
  logic       step_prev;
  logic       step_edge;
  logic       advance;

  assign step_edge = step & ~step_prev;
  assign limit     = 7'((8'd1 << rate) - 8'd1);

  // Forward: A' = ~B, B' = A.  Reverse: A' = B, B' = ~A.
  assign ring_a_n = dir ? ring_b : ~ring_b;
  assign ring_b_n = dir ? ~ring_a : ring_a;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    advance     = 1'b0;
    step_drop_n = 1'b0;
    case (state)
      IDLE: begin
        if (run) begin
          state_n = RUN;
          cnt_n   = 7'd0;
        end else if (step_edge) begin
          state_n = STEP;
        end
      end
      RUN: begin
        step_drop_n = step_edge;
        if (!run) begin
          state_n = IDLE;
          cnt_n   = 7'd0;
        end else if (cnt >= limit) begin
          advance = 1'b1;
          cnt_n   = 7'd0;
        end else begin
          cnt_n = 7'(cnt + 7'd1);
        end
      end
      STEP: begin
        advance = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // tick, wrap and step_drop are single-cycle strobes; tick acts as the
  // output-valid qualifier for the ring value presented alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 7'd0;
      ring_a    <= 1'b0;
      ring_b    <= 1'b0;
      tick      <= 1'b0;
      wrap      <= 1'b0;
      last_dir  <= 1'b0;
      step_drop <= 1'b0;
      step_prev <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      tick      <= advance;
      step_drop <= step_drop_n;
      step_prev <= step;
      wrap      <= advance & ~ring_a_n & ~ring_b_n;
      if (advance) begin
        ring_a   <= ring_a_n;
        ring_b   <= ring_b_n;
        last_dir <= dir;
      end
    end
  end

  assign io_out = {step_drop, last_dir, wrap, state, tick, ring_b, ring_a};

endmodule
